apb_requester: RTL and testbench
================================

// Module: apb_requester
// PURPOSE
//  APB4 requester (initiator) bridge. Takes single read/write commands on a
//  valid/ready port, runs one APB transfer on the apb_intf signal set, and
//  returns PRDATA/PSLVERR on a valid/ready response port. Adds a wait-state
//  timeout so a hung completer cannot stall the system. Serves as the master
//  side for APB completer DUTs and as the reference driver model.
// PARAMETERS
//  ADDR_WIDTH  32  width of cmd_addr/PADDR (matches `ADDR_WIDTH)
//  DATA_WIDTH  32  width of data buses; PSTRB = DATA_WIDTH/8 (matches `DATA_WIDTH)
//  TIMEOUT     16  max consecutive ACCESS cycles with PREADY=0; 0 disables timeout
// PORTS
//  PCLK         in   1      clock
//  PRESETn      in   1      synchronous active-low reset
//  cmd_valid    in   1      command present
//  cmd_ready    out  1      command accepted when cmd_valid&cmd_ready
//  cmd_write    in   1      1=write, 0=read
//  cmd_addr     in   AW     transfer address
//  cmd_wdata    in   DW     write data
//  cmd_strb     in   DW/8   write byte strobes
//  cmd_prot     in   3      protection attributes
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      response consumed when rsp_valid&rsp_ready
//  rsp_rdata    out  DW     read data (0 for writes and timeouts)
//  rsp_err      out  1      PSLVERR seen, or timeout
//  rsp_timeout  out  1      transfer aborted by timeout
//  PSEL/PENABLE/PWRITE out 1; PPROT out 3; PSTRB out DW/8; PADDR out AW; PWDATA out DW
//  PRDATA in DW; PREADY in 1; PSLVERR in 1   (APB4 bus, names as in apb_intf)
// BEHAVIOUR
//  - One clock PCLK; reset synchronous active-low on PRESETn. All outputs
//    registered. Reset: state=IDLE, cmd_ready=1, every other output 0.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. On cmd_valid: latch cmd fields, go SETUP, cmd_ready=0.
//  - SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PPROT/PWDATA/PSTRB valid;
//    PSTRB forced 0 and PWDATA held 0 for reads. Always -> ACCESS.
//  - ACCESS: PSEL=1, PENABLE=1, all address/control/data stable.
//    PREADY=1: capture PRDATA (reads only) and PSLVERR into rsp_*; -> RESP;
//    PSEL, PENABLE low on the next cycle.
//    PREADY=0: wait counter +1; counter = TIMEOUT (TIMEOUT!=0) -> abort:
//    PSEL/PENABLE low, rsp_err=1, rsp_timeout=1, rsp_rdata=0, -> RESP.
//    PREADY=1 in the cycle the counter hits TIMEOUT: normal completion wins.
//    PRDATA/PSLVERR are ignored while PREADY=0.
//  - RESP: rsp_valid=1, payload stable until rsp_ready; then -> IDLE,
//    rsp_valid=0, cmd_ready=1. Counter cleared on entry to SETUP.
//  - Latency: accept at edge N -> PSEL at N+1, PENABLE at N+2; zero-wait
//    rsp_valid at N+3. Max throughput 1 transfer / 4 cycles. No pipelining.
//  - PSLVERR on a read: rsp_err=1, rsp_rdata = PRDATA as sampled.
//  - PRESETn low in any state: next edge returns to reset values; in-flight
//    transfer dropped, no response issued. PSEL never held across reset.
//  - Counter width $clog2(TIMEOUT+1); saturates; unused when TIMEOUT=0.
// TESTING
//  1 write A=0x10 D=0xDEADBEEF strb=0xF, PREADY=1 -> PSEL N+1, PENABLE N+2, rsp_valid N+3, rsp_err=0
//  2 read A=0x24, PREADY low 3 ACCESS cycles then PRDATA=0x1234_5678 -> rsp_rdata=0x12345678, PSTRB=0 throughout
//  3 write with PSLVERR=1 on PREADY cycle -> rsp_err=1, rsp_timeout=0, PSEL low next cycle
//  4 TIMEOUT=16, PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0
//  5 rsp_ready low 5 cycles -> rsp_valid/payload stable, cmd_ready=0 until handshake, then cmd_ready=1
//  6 PRESETn low during ACCESS -> next edge PSEL=PENABLE=0, rsp_valid=0, cmd_ready=1

Source files
------------

// File: rtl/apb_requester.sv
// APB4 requester: accepts one command on a valid/ready port, runs one APB transfer,
// and returns the completer's result on a valid/ready response port, with a wait-state timeout.
module apb_requester #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [2:0]              PPROT,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] wait_cnt;

    // The APB address/control registers double as the latched command fields.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PPROT       <= '0;
            PSTRB       <= '0;
            PADDR       <= '0;
            PWDATA      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PWRITE    <= cmd_write;
                        PADDR     <= cmd_addr;
                        PPROT     <= cmd_prot;
                        PWDATA    <= cmd_write ? cmd_wdata : '0;
                        PSTRB     <= cmd_write ? cmd_strb : '0;
                        wait_cnt  <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // A ready completer wins even in the cycle the timeout would fire.
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (TIMEOUT != 0 && int'(wait_cnt) == TIMEOUT - 1) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else if (TIMEOUT != 0 && int'(wait_cnt) != TIMEOUT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed vector table, randomized transfers
// against a behavioural response model, and a reset-during-ACCESS sequence.
module tb_apb_requester;

    localparam int TO = 16;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [2:0]  PPROT;
    logic [3:0]  PSTRB;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;
        logic [31:0] rdata;
        logic        slverr;
        int          hold;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        int          exp_cycles;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_timeout;
    } vec_t;

    vec_t vecs [8];

    apb_requester #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PPROT(PPROT), .PSTRB(PSTRB),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Response expected from the protocol rules alone: a completer that stays
    // unready for TO or more ACCESS cycles is abandoned after exactly TO cycles.
    function automatic vec_t refModel(input vec_t t);
        vec_t r;
        logic timed_out;
        r = t;
        timed_out     = (TO != 0) && (t.waits >= TO);
        r.exp_cycles  = timed_out ? TO : t.waits + 1;
        r.exp_timeout = timed_out;
        r.exp_err     = timed_out || t.slverr;
        r.exp_rdata   = (timed_out || t.write) ? 32'h0 : t.rdata;
        r.exp_strb    = t.write ? t.strb : 4'h0;
        r.exp_wdata   = t.write ? t.wdata : 32'h0;
        return r;
    endfunction

    task automatic applyStimulus(input vec_t t);
        int n;
        logic [71:0] exp_bus;
        exp_bus = {t.addr, t.write, t.prot, t.exp_strb, t.exp_wdata};

        checkOutput("idle_cmd_ready", 128'(cmd_ready), 128'(1'b1));
        cmd_valid = 1'b1;
        cmd_write = t.write;
        cmd_addr  = t.addr;
        cmd_wdata = t.wdata;
        cmd_strb  = t.strb;
        cmd_prot  = t.prot;
        PREADY    = 1'b0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;

        checkOutput("setup_ctrl", 128'({PSEL, PENABLE, cmd_ready, rsp_valid}), 128'(4'b1000));
        checkOutput("setup_bus", 128'({PADDR, PWRITE, PPROT, PSTRB, PWDATA}), 128'(exp_bus));

        @(posedge PCLK); #1;
        n = 0;
        while (PSEL === 1'b1 && PENABLE === 1'b1 && n < 64) begin
            checkOutput("access_bus", 128'({PADDR, PWRITE, PPROT, PSTRB, PWDATA}), 128'(exp_bus));
            if (n == t.waits) begin
                PREADY  = 1'b1;
                PRDATA  = t.rdata;
                PSLVERR = t.slverr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom_range(0, 1));
            end
            n++;
            @(posedge PCLK); #1;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        checkOutput("access_cycles", 128'(n), 128'(t.exp_cycles));
        checkOutput("resp_ctrl", 128'({rsp_valid, PSEL, PENABLE, cmd_ready}), 128'(4'b1000));
        checkOutput("resp_payload", 128'({rsp_rdata, rsp_err, rsp_timeout}),
                    128'({t.exp_rdata, t.exp_err, t.exp_timeout}));

        rsp_ready = 1'b0;
        for (int h = 0; h < t.hold; h++) begin
            @(posedge PCLK); #1;
            checkOutput("hold_ctrl", 128'({rsp_valid, cmd_ready}), 128'(2'b10));
            checkOutput("hold_payload", 128'({rsp_rdata, rsp_err, rsp_timeout}),
                        128'({t.exp_rdata, t.exp_err, t.exp_timeout}));
        end
        rsp_ready = 1'b1;
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        checkOutput("after_handshake", 128'({rsp_valid, cmd_ready, PSEL}), 128'(3'b010));
    endtask

    initial begin
        vec_t t;

        vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'd0, 0,   32'h0,        1'b0, 0, 4'hF, 32'hDEADBEEF, 1,  32'h0,        1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h24, 32'hAAAA5555, 4'hF, 3'd2, 3,   32'h12345678, 1'b0, 0, 4'h0, 32'h0,        4,  32'h12345678, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h30, 32'hCAFEF00D, 4'h3, 3'd1, 0,   32'h5A5A5A5A, 1'b1, 1, 4'h3, 32'hCAFEF00D, 1,  32'h0,        1'b1, 1'b0};
        vecs[3] = '{1'b0, 32'h40, 32'h11111111, 4'h0, 3'd0, 100, 32'hFFFFFFFF, 1'b0, 0, 4'h0, 32'h0,        16, 32'h0,        1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h50, 32'h01020304, 4'hC, 3'd7, 2,   32'h0,        1'b0, 5, 4'hC, 32'h01020304, 3,  32'h0,        1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h60, 32'h0,        4'h5, 3'd4, 0,   32'h87654321, 1'b1, 0, 4'h0, 32'h0,        1,  32'h87654321, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 32'h70, 32'h0,        4'h0, 3'd3, 15,  32'h0BADF00D, 1'b0, 0, 4'h0, 32'h0,        16, 32'h0BADF00D, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h80, 32'h55AA55AA, 4'hF, 3'd0, 16,  32'h0,        1'b0, 2, 4'hF, 32'h55AA55AA, 16, 32'h0,        1'b1, 1'b1};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        cmd_prot  = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        repeat (3) @(posedge PCLK);
        #1;
        checkOutput("reset_ctrl", 128'({cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE}), 128'(5'b10000));
        checkOutput("reset_payload", 128'({rsp_rdata, rsp_err, rsp_timeout, PADDR, PWDATA, PSTRB, PPROT}), 128'(0));
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
        end

        for (int i = 0; i < 30; i++) begin
            t = vecs[0];
            t.write  = 1'($urandom_range(0, 1));
            t.addr   = $urandom;
            t.wdata  = $urandom;
            t.strb   = 4'($urandom);
            t.prot   = 3'($urandom);
            t.waits  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
            t.rdata  = $urandom;
            t.slverr = ($urandom_range(0, 3) == 0);
            t.hold   = int'($urandom_range(0, 3));
            applyStimulus(refModel(t));
        end

        // Reset in the middle of a stalled ACCESS phase must drop the transfer silently.
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h90;
        cmd_wdata = 32'hFEEDFACE;
        cmd_strb  = 4'hF;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        checkOutput("rst_pre_access", 128'({PSEL, PENABLE}), 128'(2'b11));
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b0;
        @(posedge PCLK); #1;
        checkOutput("rst_mid_access", 128'({PSEL, PENABLE, rsp_valid, cmd_ready}), 128'(4'b0001));
        PRESETn = 1'b1;
        PREADY  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge PCLK); #1;
            checkOutput("rst_no_resp", 128'({rsp_valid, PSEL, cmd_ready}), 128'(3'b001));
        end
        PREADY = 1'b0;

        t = vecs[0];
        t.write = 1'b0;
        t.addr  = 32'hA0;
        t.waits = 1;
        t.rdata = 32'h13572468;
        t.slverr = 1'b0;
        t.hold  = 0;
        applyStimulus(refModel(t));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
